// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - fetch PC, credit-limited imem requests and instruction FIFO
module fetch_queue_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int QUEUE_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         redirect_valid,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   output logic                         imem_req_valid,
   output logic [ADDR_WIDTH-1:0]        imem_req_addr,
   input  logic                         imem_req_ready,
   input  logic                         imem_resp_valid,
   input  logic [INSTR_WIDTH-1:0]       imem_resp_data,
   output logic                         if_valid,
   output logic [ADDR_WIDTH-1:0]        if_pc,
   output logic [INSTR_WIDTH-1:0]       if_instr,
   input  logic                         if_ready,
   output logic [$clog2(QUEUE_DEPTH):0] outstanding
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);
   localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [ADDR_WIDTH-1:0]  fetch_pc;
   logic [ADDR_WIDTH-1:0]  resp_pc;
   logic [CNT_W-1:0]       drop_cnt;
   logic [CNT_W-1:0]       count;
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [ADDR_WIDTH-1:0]  q_pc    [QUEUE_DEPTH];
   logic [INSTR_WIDTH-1:0] q_instr [QUEUE_DEPTH];

   logic [CNT_W:0]         credit_used;
   logic                   req_fire;
   logic                   resp_fire;
   logic                   resp_drop;
   logic                   push;
   logic                   pop;
   logic [CNT_W-1:0]       inc_req;
   logic [CNT_W-1:0]       dec_resp;
   logic [CNT_W-1:0]       inc_push;
   logic [CNT_W-1:0]       dec_pop;
   logic [CNT_W-1:0]       outstanding_after_resp;
   logic [ADDR_WIDTH-1:0]  redirect_target;
   logic                   unused_redirect_lsbs;

   // Queued entries plus in-flight requests may never exceed the FIFO size,
   // so every response always has a slot waiting for it.
   assign credit_used    = {1'b0, count} + {1'b0, outstanding};
   assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDIT_LIMIT);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is spurious and leaves state alone.
   assign resp_fire = imem_resp_valid && (outstanding != '0);
   assign resp_drop = resp_fire && (drop_cnt != '0);
   assign push      = resp_fire && (drop_cnt == '0) && !redirect_valid;
   assign pop       = if_valid && if_ready && !redirect_valid;

   assign inc_req  = req_fire  ? CNT_ONE : '0;
   assign dec_resp = resp_fire ? CNT_ONE : '0;
   assign inc_push = push      ? CNT_ONE : '0;
   assign dec_pop  = pop       ? CNT_ONE : '0;
   assign outstanding_after_resp = outstanding - dec_resp;

   assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign if_valid = (count != '0);
   assign if_pc    = if_valid ? q_pc[rd_ptr]    : '0;
   assign if_instr = if_valid ? q_instr[rd_ptr] : NOP;

   // Fetch/response PCs, credit counters and FIFO pointers; redirect flushes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_target;
         resp_pc     <= redirect_target;
         outstanding <= outstanding_after_resp;
         drop_cnt    <= outstanding_after_resp;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
         end
         outstanding <= outstanding + inc_req - dec_resp;
         if (resp_drop) begin
            drop_cnt <= drop_cnt - CNT_ONE;
         end
         if (push) begin
            wr_ptr  <= wr_ptr + PTR_W'(1);
            resp_pc <= resp_pc + ADDR_WIDTH'(4);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + inc_push - dec_pop;
      end
   end

   // FIFO storage; the tail slot takes the kept response with its PC
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]    <= resp_pc;
         q_instr[wr_ptr] <= imem_resp_data;
      end
   end

   // Credit accounting must make a push into a full, non-draining FIFO impossible
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && !pop && (count == FULL)));
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb/tb_fetch_queue_unit.sv - table, directed and randomized checks of fetch_queue_unit
module tb_fetch_queue_unit;

   localparam int QD = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic [2:0]  outstanding;

   fetch_queue_unit #(
      .ADDR_WIDTH(32),
      .INSTR_WIDTH(32),
      .QUEUE_DEPTH(QD),
      .RESET_PC(32'h0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid),
      .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data),
      .if_valid(if_valid),
      .if_pc(if_pc),
      .if_instr(if_instr),
      .if_ready(if_ready),
      .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference: memory requests tagged stale on redirect, FIFO as a queue of PCs
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } req_t;

   req_t        pend[$];
   logic [31:0] mq[$];
   logic [31:0] m_fetch_pc;
   int          cyc;
   int          lat;
   bit          resp_en;
   bit          stale_resp;
   bit          e_rv;

   typedef struct {
      bit          if_rdy;
      bit          rv;
      logic [31:0] ra;
      bit          iv;
      logic [31:0] ipc;
      int          outs;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic settle();
      if (rst) begin
         pend.delete();
         mq.delete();
         m_fetch_pc = 32'h0;
      end
      if (resp_en && pend.size() != 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(pend[0].addr);
      end else if (stale_resp && pend.size() == 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hDEAD_BEEF;
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
      #2;
   endtask

   task automatic model_check();
      e_rv = !rst && !redirect_valid && ((mq.size() + pend.size()) < QD);
      check("req_valid", 32'(imem_req_valid), 32'(e_rv));
      if (e_rv) check("req_addr", imem_req_addr, m_fetch_pc);
      check("if_valid", 32'(if_valid), 32'(mq.size() != 0));
      check("if_pc", if_pc, (mq.size() != 0) ? mq[0] : 32'h0);
      check("if_instr", if_instr, (mq.size() != 0) ? instr_of(mq[0]) : NOP);
      check("outstanding", 32'(outstanding), 32'(pend.size()));
   endtask

   task automatic advance();
      req_t r;
      bit   rf;
      bit   rq;
      bit   dq;
      rf = 1'b0;
      if (!rst) begin
         rq = e_rv && imem_req_ready;
         dq = (mq.size() != 0) && if_ready;
         if (imem_resp_valid && pend.size() != 0) begin
            r  = pend.pop_front();
            rf = 1'b1;
         end
         if (redirect_valid) begin
            mq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
         end else begin
            if (dq) void'(mq.pop_front());
            if (rf && !r.stale) mq.push_back(r.addr);
            if (rq) begin
               pend.push_back('{m_fetch_pc, cyc + lat, 1'b0});
               m_fetch_pc = m_fetch_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      settle();
      model_check();
      advance();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      stale_resp = 1'b0;
      resp_en = 1'b1;
      step();
      rst = 1'b0;
   endtask

   bit          found;
   bit          prev_stall;
   logic [31:0] prev_addr;

   initial begin
      // cycle: if_ready, req_valid, req_addr, if_valid, if_pc, outstanding
      vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00, 0};
      vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00, 1};
      vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h00, 1};
      vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h00, 1};
      vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 1};
      vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 0};
      vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 0};
      vecs[7]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h04, 0};
      vecs[8]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 1};
      vecs[9]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 1};
      vecs[10] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 1};
      vecs[11] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 1};

      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      imem_req_ready = 1'b0;
      if_ready = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data = 32'h0;
      cyc = 0;
      lat = 1;
      resp_en = 1'b1;
      stale_resp = 1'b0;
      m_fetch_pc = 32'h0;
      #1;

      // Reset state
      settle();
      model_check();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_if_instr", if_instr, NOP);
      advance();

      // Fill with if_ready low, then drain (1-cycle memory)
      rst = 1'b0;
      imem_req_ready = 1'b1;
      lat = 1;
      for (int k = 0; k < 12; k++) begin
         if_ready = vecs[k].if_rdy;
         settle();
         model_check();
         check("tbl_req_valid", 32'(imem_req_valid), 32'(vecs[k].rv));
         if (vecs[k].rv) check("tbl_req_addr", imem_req_addr, vecs[k].ra);
         check("tbl_if_valid", 32'(if_valid), 32'(vecs[k].iv));
         check("tbl_if_pc", if_pc, vecs[k].ipc);
         check("tbl_outstanding", 32'(outstanding), 32'(vecs[k].outs));
         advance();
      end

      // Streaming from reset with 1-cycle memory
      do_reset();
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (8) step();

      // Redirect with two requests in flight on a 3-cycle memory
      do_reset();
      lat = 3;
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      step();
      step();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      settle();
      model_check();
      check("t3_outstanding", 32'(outstanding), 32'd2);
      advance();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         settle();
         model_check();
         if (if_valid) begin
            check("t3_first_pc", if_pc, 32'h100);
            found = 1'b1;
         end
         advance();
      end
      check("t3_if_valid_seen", 32'(found), 32'd1);
      repeat (6) step();

      // Redirect together with a response and a dequeue
      do_reset();
      lat = 1;
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (5) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h203;
      settle();
      model_check();
      check("t4_if_valid_before", 32'(if_valid), 32'd1);
      check("t4_outstanding_before", 32'(outstanding), 32'd1);
      advance();
      redirect_valid = 1'b0;
      settle();
      model_check();
      check("t4_if_valid", 32'(if_valid), 32'd0);
      check("t4_if_instr", if_instr, NOP);
      check("t4_outstanding", 32'(outstanding), 32'd0);
      check("t4_req_valid", 32'(imem_req_valid), 32'd1);
      check("t4_req_addr", imem_req_addr, 32'h200);
      advance();
      repeat (6) step();

      // Memory ready toggling every cycle
      do_reset();
      lat = 2;
      if_ready = 1'b1;
      prev_stall = 1'b0;
      prev_addr = 32'h0;
      for (int k = 0; k < 24; k++) begin
         imem_req_ready = k[0];
         settle();
         model_check();
         if (prev_stall) check("t5_addr_stable", imem_req_addr, prev_addr);
         prev_stall = imem_req_valid && !imem_req_ready;
         prev_addr = imem_req_addr;
         advance();
      end

      // Reset mid-burst with three outstanding, then stray responses
      do_reset();
      lat = 4;
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      repeat (3) step();
      check("t6_outstanding_pre", 32'(outstanding), 32'd3);
      rst = 1'b1;
      imem_req_ready = 1'b0;
      settle();
      model_check();
      check("t6_async_outstanding", 32'(outstanding), 32'd0);
      check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
      check("t6_async_if_pc", if_pc, 32'h0);
      advance();
      rst = 1'b0;
      stale_resp = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         model_check();
         check("t6_stale_outstanding", 32'(outstanding), 32'd0);
         check("t6_stale_if_valid", 32'(if_valid), 32'd0);
         advance();
      end
      stale_resp = 1'b0;
      imem_req_ready = 1'b1;
      settle();
      model_check();
      check("t6_restart_addr", imem_req_addr, 32'h0);
      advance();
      if_ready = 1'b1;
      repeat (8) step();

      // Randomized traffic against the reference model
      do_reset();
      lat = 1;
      for (int k = 0; k < 3000; k++) begin
         if (pend.size() == 0 && $urandom_range(0, 9) == 0) lat = int'($urandom_range(1, 4));
         if_ready = ($urandom_range(0, 9) < 7);
         imem_req_ready = ($urandom_range(0, 9) < 7);
         resp_en = ($urandom_range(0, 9) < 8);
         redirect_valid = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else redirect_pc = $urandom();
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      redirect_valid = 1'b0;
      repeat (4) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order, pipelined requests to an instruction memory with variable latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to IF/ID through a valid/ready handshake.
- Handles taken-branch/jump redirects by flushing the FIFO and discarding responses for requests already in flight.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- INSTR_WIDTH, 32, instruction width.
- QUEUE_DEPTH, 4, FIFO entries; also the cap on queued plus in-flight requests. Must be a power of 2, ≥2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  ADDR_WIDTH  fetch address; always word aligned.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_resp_valid  in  1  response valid; responses return in request order.
- imem_resp_data  in  INSTR_WIDTH  returned instruction.
- if_valid  out  1  FIFO head valid toward IF/ID.
- if_pc  out  ADDR_WIDTH  PC of the head entry.
- if_instr  out  INSTR_WIDTH  instruction of the head entry.
- if_ready  in  1  IF/ID write enable; low during a hazard stall.
- outstanding  out  $clog2(QUEUE_DEPTH)+1  requests accepted but not yet responded to (debug/verification).

Behaviour:
- **Reset** (async, any time, including mid-burst):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
  - First request is issued the first cycle after rst deasserts.
- **Empty FIFO outputs:** if_pc=0 and if_instr=NOP whenever the FIFO is empty.
- **Credit:** imem_req_valid = !redirect_valid && (fifo_count + outstanding < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
- **Request accept** (req_valid && req_ready): outstanding += 1 and fetch_pc += 4.
  - fetch_pc wraps modulo 2^ADDR_WIDTH.
  - Request must be held stable while ready=0.
- **Response:** outstanding -= 1.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Otherwise push {pc, instr}; the pushed pc comes from a resp_pc register that starts at the post-redirect/reset PC and advances by 4 per accepted response.
  - Response with outstanding==0 is ignored, with no state change.
- **Latency:**
  - Request accepted cycle N, response cycle M≥N+1, if_valid high at M+1.
  - With 1-cycle memory and if_ready=1, one instruction is delivered per cycle.
- **Dequeue:** if_valid && if_ready pops the head.
  - Push and pop in the same cycle is legal on any fill level; count is unchanged.
- **Full FIFO:** credit rule guarantees no overflow. Push while full is a design error; flag with an assertion.
- **Redirect** (redirect_valid=1 at cycle N), at edge N:
  - FIFO cleared; any handshake that cycle is discarded (IF/ID flushes in parallel).
  - fetch_pc and resp_pc set to {redirect_pc[ADDR_WIDTH-1:2],2'b0}.
  - drop_cnt = outstanding after this cycle's response (minus 1 if a response arrived, whether kept or dropped). No request is accepted in cycle N.
  - First request to the new target is issued in cycle N+1 if credit allows.
  - Back-to-back redirects: the last one wins. drop_cnt recomputed each time, never exceeds outstanding.
- **Simultaneous precedence:** rst > redirect > response push / dequeue.

Test Plan:
1. Reset release, 1-cycle memory, if_ready=1 → requests 0x0,0x4,0x8,… on consecutive cycles; if_valid from cycle 2; if_pc 0x0,0x4,0x8 with matching instrs.
2. if_ready=0 from start, QUEUE_DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0. FIFO holds PCs 0x0–0xC. Raise if_ready → drained in order, fetching resumes at 0x10.
3. 3-cycle memory latency, 2 requests in flight, redirect_pc=0x100 → both old responses discarded (drop_cnt 2→0). Next delivered if_pc=0x100; no stale PC ever reaches the output.
4. Redirect in the same cycle as a response and a dequeue → response dropped, FIFO empty next cycle, if_instr=NOP. Request to the redirect target (0x203 given → addr 0x200) issued next cycle.
5. imem_req_ready toggling 0/1 every cycle → imem_req_addr stable while stalled; delivered PC sequence contiguous by 4.
6. Assert rst mid-burst with 3 outstanding → all outputs at reset values asynchronously. Stale responses after release are ignored; fetch restarts at RESET_PC.
